split_access_sequencer: RTL and testbench

- Parametrised, sequential successor to the cache input-alignment stage.
- Accepts one naturally-sized load/store request (1..MAX_BYTES bytes) at any byte address.
- Splits it into one or two line-aligned accesses (P0, P1), with shifted write data and byte enables.
- Issues the accesses in order over a single valid/ready cache port, merges the two read returns into one right-justified result, and returns a completion on a valid/ready response port.

---
 rtl/split_access_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_split_access_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_access_sequencer.sv
// ---------------------------------------------------------------------------
// split_access_sequencer
//
// Purpose:
//   Takes one naturally-sized load/store request (1..MAX_BYTES bytes) at any
//   byte address. If the request crosses a cache-line boundary it becomes two
//   accesses, P0 and P1. Otherwise it is a single access.
//   The block issues the access(es) in order on one valid/ready cache port
//   and merges the load returns into a right-justified result. It then
//   presents a completion on a valid/ready output port.
//   Only one request is in flight at a time.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous, active-low reset
//   req_valid  - request present
//   req_ready  - request accepted on req_valid && req_ready (IDLE only)
//   req_addr   - byte address of the request
//   req_size   - log2 of the byte count (saturated to MAX_BYTES)
//   req_wr     - 1 = store, 0 = load
//   req_wdata  - right-justified store data
//   req_id     - request tag, echoed on completion
//   mem_valid  - cache access present
//   mem_ready  - cache accepts the access
//   mem_addr   - line-aligned access address
//   mem_wr     - access is a store
//   mem_wdata  - store data positioned within the line
//   mem_be     - byte enables within the line
//   mem_part   - 0 = first access (P0), 1 = second access (P1)
//   rsp_valid  - load return for the outstanding load access
//   rsp_rdata  - returned cache line
//   out_valid  - completion present
//   out_ready  - completion consumed
//   out_rdata  - right-justified, zero-extended load result (0 for stores)
//   out_id     - tag of the completed request
//   out_split  - request needed two accesses
// ---------------------------------------------------------------------------
module split_access_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int MAX_BYTES  = 8,
  parameter int ID_W       = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_wr,
  input  logic [8*MAX_BYTES-1:0]  req_wdata,
  input  logic [ID_W-1:0]         req_id,

  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_wr,
  output logic [8*LINE_BYTES-1:0] mem_wdata,
  output logic [LINE_BYTES-1:0]   mem_be,
  output logic                    mem_part,

  input  logic                    rsp_valid,
  input  logic [8*LINE_BYTES-1:0] rsp_rdata,

  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*MAX_BYTES-1:0]  out_rdata,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_split
);

  // Offset width within a line, and a count width wide enough to hold
  // off + n (which is below 2*LINE_BYTES) without overflow.
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CW    = OFF_W + 2;
  localparam int LW    = 8 * LINE_BYTES;
  localparam int DW    = 8 * MAX_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    DONE
  } state_e;

  state_e                  state_q;

  // Request fields captured at acceptance and used by later states.
  logic                    wr_q;
  logic                    split_q;
  logic [ID_W-1:0]         id_q;
  logic [CW-1:0]           off_q;
  logic [CW-1:0]           n0_q;
  logic [CW-1:0]           n1_q;
  logic [ADDR_W-1:0]       p1Addr_q;
  logic [LINE_BYTES-1:0]   p1Be_q;
  logic [LW-1:0]           p1Wdata_q;
  logic [DW-1:0]           result_q;

  // Registered port outputs.
  logic                    memValid_q;
  logic [ADDR_W-1:0]       memAddr_q;
  logic                    memWr_q;
  logic [LW-1:0]           memWdata_q;
  logic [LINE_BYTES-1:0]   memBe_q;
  logic                    memPart_q;
  logic                    outValid_q;
  logic [DW-1:0]           outRdata_q;
  logic [ID_W-1:0]         outId_q;
  logic                    outSplit_q;

  // Request-side decode, evaluated on the raw request inputs.
  logic [3:0]              rawN;
  logic [CW-1:0]           reqN;
  logic [CW-1:0]           reqOff;
  logic [CW-1:0]           reqN0;
  logic [CW-1:0]           reqN1;
  logic                    reqSplit;
  logic [LINE_BYTES-1:0]   beMask0;
  logic [LINE_BYTES-1:0]   reqBe0;
  logic [LINE_BYTES-1:0]   reqBe1;
  logic [LW-1:0]           reqWdataExt;
  logic [LW-1:0]           reqWdata0;
  logic [LW-1:0]           reqWdata1;
  logic [ADDR_W-1:0]       reqP0Addr;
  logic [ADDR_W-1:0]       reqP1Addr;

  // Read-return merge values.
  logic [DW-1:0]           rspAligned;
  logic [DW-1:0]           merge0;
  logic [DW-1:0]           rspLow;
  logic [DW-1:0]           merge1;

  // The request is sampled only in IDLE, so every derived quantity for both
  // parts is decoded here, straight from the request inputs. All of it is
  // captured in one edge at acceptance. A LINE_BYTES-wide mask built as
  // (1<<n)-1 wraps to all ones when n equals LINE_BYTES. That is the wanted
  // truncated result, so no wider temporary is needed.
  always_comb begin
    rawN = 4'd1 << req_size;
    if (int'(rawN) > MAX_BYTES) begin
      reqN = CW'(MAX_BYTES);
    end else begin
      reqN = CW'(rawN);
    end
    reqOff   = CW'(req_addr[OFF_W-1:0]);
    reqSplit = (reqOff + reqN) > CW'(LINE_BYTES);
    reqN0    = reqSplit ? (CW'(LINE_BYTES) - reqOff) : reqN;
    reqN1    = reqN - reqN0;

    beMask0 = (LINE_BYTES'(1) << reqN) - LINE_BYTES'(1);
    reqBe0  = beMask0 << reqOff;
    reqBe1  = (LINE_BYTES'(1) << reqN1) - LINE_BYTES'(1);

    reqWdataExt           = '0;
    reqWdataExt[DW-1:0]   = req_wdata;
    reqWdata0             = reqWdataExt << {reqOff, 3'b000};
    reqWdata1             = reqWdataExt >> {reqN0, 3'b000};

    reqP0Addr             = req_addr;
    reqP0Addr[OFF_W-1:0]  = '0;
    reqP1Addr             = reqP0Addr + ADDR_W'(LINE_BYTES);
  end

  // Byte gathering for load returns. The P0 line is shifted down by the
  // start offset, and its first n0 bytes become result bytes 0..n0-1. The
  // first n1 bytes of the P1 line are placed above those. Every byte beyond
  // the request size stays zero.
  always_comb begin
    rspAligned = DW'(rsp_rdata >> {off_q, 3'b000});
    merge0     = '0;
    rspLow     = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (CW'(i) < n0_q) begin
        merge0[8*i +: 8] = rspAligned[8*i +: 8];
      end
      if (CW'(i) < n1_q) begin
        rspLow[8*i +: 8] = rsp_rdata[8*i +: 8];
      end
    end
    merge1 = result_q | (rspLow << {n0_q, 3'b000});
  end

  // Sequencer. Every port output is a register that is loaded on the
  // transition into the state that presents it. This keeps mem_* and out_*
  // stable while they wait for their ready. P1's address, enables and data
  // were computed at acceptance, so starting P1 only copies registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      split_q    <= 1'b0;
      id_q       <= '0;
      off_q      <= '0;
      n0_q       <= '0;
      n1_q       <= '0;
      p1Addr_q   <= '0;
      p1Be_q     <= '0;
      p1Wdata_q  <= '0;
      result_q   <= '0;
      memValid_q <= 1'b0;
      memAddr_q  <= '0;
      memWr_q    <= 1'b0;
      memWdata_q <= '0;
      memBe_q    <= '0;
      memPart_q  <= 1'b0;
      outValid_q <= 1'b0;
      outRdata_q <= '0;
      outId_q    <= '0;
      outSplit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            split_q    <= reqSplit;
            id_q       <= req_id;
            off_q      <= reqOff;
            n0_q       <= reqN0;
            n1_q       <= reqN1;
            p1Addr_q   <= reqP1Addr;
            p1Be_q     <= reqBe1;
            p1Wdata_q  <= reqWdata1;
            result_q   <= '0;
            memValid_q <= 1'b1;
            memAddr_q  <= reqP0Addr;
            memWr_q    <= req_wr;
            memWdata_q <= reqWdata0;
            memBe_q    <= reqBe0;
            memPart_q  <= 1'b0;
            state_q    <= ISSUE0;
          end
        end

        ISSUE0: begin
          if (mem_ready) begin
            if (!wr_q) begin
              memValid_q <= 1'b0;
              state_q    <= WAIT0;
            end else if (split_q) begin
              memAddr_q  <= p1Addr_q;
              memWdata_q <= p1Wdata_q;
              memBe_q    <= p1Be_q;
              memPart_q  <= 1'b1;
              state_q    <= ISSUE1;
            end else begin
              memValid_q <= 1'b0;
              outValid_q <= 1'b1;
              outRdata_q <= '0;
              outId_q    <= id_q;
              outSplit_q <= 1'b0;
              state_q    <= DONE;
            end
          end
        end

        WAIT0: begin
          if (rsp_valid) begin
            if (split_q) begin
              result_q   <= merge0;
              memValid_q <= 1'b1;
              memAddr_q  <= p1Addr_q;
              memWdata_q <= p1Wdata_q;
              memBe_q    <= p1Be_q;
              memPart_q  <= 1'b1;
              state_q    <= ISSUE1;
            end else begin
              outValid_q <= 1'b1;
              outRdata_q <= merge0;
              outId_q    <= id_q;
              outSplit_q <= 1'b0;
              state_q    <= DONE;
            end
          end
        end

        ISSUE1: begin
          if (mem_ready) begin
            memValid_q <= 1'b0;
            if (wr_q) begin
              outValid_q <= 1'b1;
              outRdata_q <= '0;
              outId_q    <= id_q;
              outSplit_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q    <= WAIT1;
            end
          end
        end

        WAIT1: begin
          if (rsp_valid) begin
            outValid_q <= 1'b1;
            outRdata_q <= merge1;
            outId_q    <= id_q;
            outSplit_q <= 1'b1;
            state_q    <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Requests are taken only from IDLE. This depends on state alone, so a
  // completion handshake in DONE cannot bypass into a new acceptance.
  assign req_ready = (state_q == IDLE);

  assign mem_valid = memValid_q;
  assign mem_addr  = memAddr_q;
  assign mem_wr    = memWr_q;
  assign mem_wdata = memWdata_q;
  assign mem_be    = memBe_q;
  assign mem_part  = memPart_q;

  assign out_valid = outValid_q;
  assign out_rdata = outRdata_q;
  assign out_id    = outId_q;
  assign out_split = outSplit_q;

endmodule

// File: tb/tb_split_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_split_access_sequencer
//
// Directed bench for split_access_sequencer with the default parameters
// (32-bit address, 16-byte lines, 8-byte max access, 7-bit tag).
// Inputs are driven and outputs are sampled 1 time unit after each rising
// edge. Every expected value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_split_access_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [1:0]   req_size;
  logic         req_wr;
  logic [63:0]  req_wdata;
  logic [6:0]   req_id;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic         mem_wr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_be;
  logic         mem_part;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_rdata;
  logic [6:0]   out_id;
  logic         out_split;

  int checks = 0;
  int errors = 0;

  split_access_sequencer #(
    .ADDR_W(32), .LINE_BYTES(16), .MAX_BYTES(8), .ID_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_wr(req_wr), .req_wdata(req_wdata), .req_id(req_id),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_part(mem_part),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_id(out_id), .out_split(out_split)
  );

  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMem(input string tag, input logic v, input logic [31:0] a,
                          input logic [15:0] be, input logic [127:0] wd,
                          input logic w, input logic p);
    checkOutput({tag, ".mem_valid"}, mem_valid, v);
    checkOutput({tag, ".mem_addr"},  mem_addr,  a);
    checkOutput({tag, ".mem_be"},    mem_be,    be);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, wd);
    checkOutput({tag, ".mem_wr"},    mem_wr,    w);
    checkOutput({tag, ".mem_part"},  mem_part,  p);
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [63:0] rd,
                          input logic [6:0] id, input logic sp);
    checkOutput({tag, ".out_valid"}, out_valid, v);
    checkOutput({tag, ".out_rdata"}, out_rdata, rd);
    checkOutput({tag, ".out_id"},    out_id,    id);
    checkOutput({tag, ".out_split"}, out_split, sp);
  endtask

  // Present a request for exactly one edge, then scramble the request
  // fields so that any late sampling by the design shows up.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size,
                               input logic wr, input logic [63:0] wdata,
                               input logic [6:0] id);
    checkOutput("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_size  = size;
    req_wr    = wr;
    req_wdata = wdata;
    req_id    = id;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_size  = 2'd3;
    req_wr    = ~wr;
    req_wdata = '1;
    req_id    = '0;
    checkOutput("req_ready_busy", req_ready, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wr    = 1'b0;
    req_wdata = '0;
    req_id    = '0;
    mem_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    out_ready = 1'b1;

    // Reset values
    #2;
    checkOutput("rst.req_ready", req_ready, 1'b1);
    checkMem("rst", 1'b0, 32'h0, 16'h0, 128'h0, 1'b0, 1'b0);
    checkOut("rst", 1'b0, 64'h0, 7'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Aligned load: 0x1004, 4 bytes
    applyStimulus(32'h0000_1004, 2'd2, 1'b0, 64'h0, 7'h05);
    checkMem("t1_p0", 1'b1, 32'h0000_1000, 16'h00F0, 128'h0, 1'b0, 1'b0);
    checkOutput("t1_out_early", out_valid, 1'b0);
    tick();
    checkOutput("t1_mem_drop", mem_valid, 1'b0);
    rsp_valid = 1'b1;
    rsp_rdata = 128'hAAAAAAAA_BBBBBBBB_44332211_CCCCCCCC;
    tick();
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    checkOut("t1_done", 1'b1, 64'h44332211, 7'h05, 1'b0);
    tick();
    checkOutput("t1_out_consumed", out_valid, 1'b0);

    // Split load: 0x100C, 8 bytes
    applyStimulus(32'h0000_100C, 2'd3, 1'b0, 64'h0, 7'h12);
    checkMem("t2_p0", 1'b1, 32'h0000_1000, 16'hF000, 128'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t2_mem_drop0", mem_valid, 1'b0);
    rsp_valid = 1'b1;
    rsp_rdata = 128'h04030201_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    tick();
    rsp_valid = 1'b0;
    checkMem("t2_p1", 1'b1, 32'h0000_1010, 16'h000F, 128'h0, 1'b0, 1'b1);
    checkOutput("t2_out_early", out_valid, 1'b0);
    tick();
    checkOutput("t2_mem_drop1", mem_valid, 1'b0);
    rsp_valid = 1'b1;
    rsp_rdata = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_08070605;
    tick();
    rsp_valid = 1'b0;
    checkOut("t2_done", 1'b1, 64'h08070605_04030201, 7'h12, 1'b1);
    tick();
    checkOutput("t2_out_consumed", out_valid, 1'b0);

    // Split store: 0x100E, 4 bytes
    applyStimulus(32'h0000_100E, 2'd2, 1'b1, 64'hDDCCBBAA, 7'h33);
    checkMem("t3_p0", 1'b1, 32'h0000_1000, 16'hC000,
             128'hBBAA0000_00000000_00000000_00000000, 1'b1, 1'b0);
    tick();
    checkMem("t3_p1", 1'b1, 32'h0000_1010, 16'h0003, 128'h0000DDCC, 1'b1, 1'b1);
    checkOutput("t3_out_early", out_valid, 1'b0);
    tick();
    checkOutput("t3_mem_drop", mem_valid, 1'b0);
    checkOut("t3_done", 1'b1, 64'h0, 7'h33, 1'b0 | 1'b1);
    tick();

    // Non-split store: completion visible one edge after the handshake
    applyStimulus(32'h0000_3000, 2'd3, 1'b1, 64'h01020304_05060708, 7'h44);
    checkMem("t4_p0", 1'b1, 32'h0000_3000, 16'h00FF, 128'h01020304_05060708, 1'b1, 1'b0);
    tick();
    checkOut("t4_done", 1'b1, 64'h0, 7'h44, 1'b0);
    tick();

    // Backpressure: cache stalls 5 edges, then the consumer stalls 3 edges
    mem_ready = 1'b0;
    out_ready = 1'b0;
    applyStimulus(32'h0000_2003, 2'd0, 1'b0, 64'h0, 7'h21);
    for (int i = 0; i < 5; i++) begin
      checkMem("t5_hold", 1'b1, 32'h0000_2000, 16'h0008, 128'h0, 1'b0, 1'b0);
      checkOutput("t5_req_ready", req_ready, 1'b0);
      tick();
    end
    checkMem("t5_hold_last", 1'b1, 32'h0000_2000, 16'h0008, 128'h0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick();
    checkOutput("t5_mem_drop", mem_valid, 1'b0);
    rsp_valid = 1'b1;
    rsp_rdata = 128'h12345678_9ABCDEF0_11111111_5A222222;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOut("t5_out_hold", 1'b1, 64'h5A, 7'h21, 1'b0);
      checkOutput("t5_no_dup", mem_valid, 1'b0);
      checkOutput("t5_req_ready_done", req_ready, 1'b0);
      // Stray returns while waiting on the consumer must be ignored
      rsp_valid = 1'b1;
      rsp_rdata = '1;
      tick();
    end
    rsp_valid = 1'b0;
    checkOut("t5_out_hold_last", 1'b1, 64'h5A, 7'h21, 1'b0);
    out_ready = 1'b1;
    tick();
    checkOutput("t5_out_consumed", out_valid, 1'b0);

    // Address wrap, then reset while waiting for the P1 return
    applyStimulus(32'hFFFF_FFFC, 2'd3, 1'b0, 64'h0, 7'h6A);
    checkMem("t6_p0", 1'b1, 32'hFFFF_FFF0, 16'hF000, 128'h0, 1'b0, 1'b0);
    tick();
    rsp_valid = 1'b1;
    rsp_rdata = 128'hA4A3A2A1_00000000_00000000_00000000;
    tick();
    rsp_valid = 1'b0;
    checkMem("t6_p1", 1'b1, 32'h0000_0000, 16'h000F, 128'h0, 1'b0, 1'b1);
    tick();
    checkOutput("t6_in_wait1", mem_valid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst.req_ready", req_ready, 1'b1);
    checkMem("t6_rst", 1'b0, 32'h0, 16'h0, 128'h0, 1'b0, 1'b0);
    checkOut("t6_rst", 1'b0, 64'h0, 7'h0, 1'b0);
    rsp_valid = 1'b1;
    rsp_rdata = 128'h00000000_00000000_00000000_08070605;
    tick();
    tick();
    rsp_valid = 1'b0;
    rst_n = 1'b1;
    checkOutput("t6_post_rst_out", out_valid, 1'b0);
    tick();
    checkOutput("t6_no_completion", out_valid, 1'b0);

    // Normal request after the reset
    applyStimulus(32'h0000_0040, 2'd3, 1'b0, 64'h0, 7'h7F);
    checkMem("t7_p0", 1'b1, 32'h0000_0040, 16'h00FF, 128'h0, 1'b0, 1'b0);
    tick();
    rsp_valid = 1'b1;
    rsp_rdata = 128'h99999999_99999999_11223344_55667788;
    tick();
    rsp_valid = 1'b0;
    checkOut("t7_done", 1'b1, 64'h11223344_55667788, 7'h7F, 1'b0);
    tick();
    checkOutput("t7_out_consumed", out_valid, 1'b0);
    checkOutput("t7_req_ready", req_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
